// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module      : dmem_access_ctrl
// Description : MEM-stage data-memory access controller. Issues one load/store
//               on a valid/ready port, waits for the response (with timeout)
//               and presents raw_dmem/LdSel/shamt to the load-select mux.
//               Optional macro DMEM_MISALIGN_TRAP_EN traps misaligned H/HU/W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic [31:0] raw_dmem,
   output logic [2:0]  LdSel,
   output logic [1:0]  shamt,
   output logic        ld_valid,
   output logic        busy,
   output logic        timeout_err,
   output logic        misalign_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [2:0] c_SZ_B  = 3'b000;
   localparam logic [2:0] c_SZ_H  = 3'b001;
   localparam logic [2:0] c_SZ_W  = 3'b010;
   localparam logic [2:0] c_SZ_HU = 3'b100;
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic [2:0]        r_size;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_raw;
   logic              r_timeout;
   logic              w_expire;
   logic              w_misalign;
   logic [3:0]        w_wmask;
   logic [31:0]       w_wdata;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic              r_misalign;

   // Misalignment is judged on the incoming request so the trap can skip REQ.
   assign w_misalign = (((req_size == c_SZ_H) || (req_size == c_SZ_HU)) && req_addr[0])
                     || ((req_size == c_SZ_W) && (req_addr[1:0] != 2'b00));
   assign misalign_err = (r_state == S_DONE) && r_misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else if ((r_state == S_IDLE) && req_valid) begin
         r_misalign <= w_misalign;
      end
   end
`else
   assign w_misalign   = 1'b0;
   assign misalign_err = 1'b0;
`endif

   assign w_expire = (r_cnt == c_CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_next = w_misalign ? S_DONE : S_REQ;
         S_REQ:   if (mem_req_ready) w_next = S_WAIT;
         S_WAIT:  if (mem_resp_valid || w_expire) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we      <= 1'b0;
         r_size    <= 3'b000;
         r_addr    <= 32'h0;
         r_wdata   <= 32'h0;
         r_cnt     <= '0;
         r_raw     <= 32'h0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we      <= req_we;
                  r_size    <= req_size;
                  r_addr    <= req_addr;
                  r_wdata   <= req_wdata;
                  r_timeout <= 1'b0;
                  if (w_misalign) r_raw <= 32'h0;
               end
            end
            S_REQ: begin
               if (mem_req_ready) r_cnt <= '0;
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               // A response on the expiry cycle takes priority over the timeout.
               if (mem_resp_valid) begin
                  if (!r_we) r_raw <= mem_resp_data;
               end else if (w_expire) begin
                  r_raw     <= 32'h0;
                  r_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_wmask = 4'b0000;
      w_wdata = r_wdata;
      case (r_size)
         c_SZ_B: begin
            w_wmask = 4'b0001 << r_addr[1:0];
            w_wdata = {4{r_wdata[7:0]}};
         end
         c_SZ_H: begin
            w_wmask = 4'b0011 << {r_addr[1], 1'b0};
            w_wdata = {2{r_wdata[15:0]}};
         end
         c_SZ_W: begin
            w_wmask = 4'b1111;
         end
         default: ;
      endcase
   end

   assign mem_req_valid = (r_state == S_REQ);
   assign mem_we        = r_we;
   assign mem_addr      = {r_addr[31:2], 2'b00};
   assign mem_wmask     = r_we ? w_wmask : 4'b0000;
   assign mem_wdata     = w_wdata;

   assign req_ready   = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign ld_valid    = (r_state == S_DONE);
   assign timeout_err = (r_state == S_DONE) && r_timeout;
   assign raw_dmem    = r_raw;
   assign LdSel       = r_size;
   assign shamt       = r_addr[1:0];

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Self-checking bench for dmem_access_ctrl: vector table with a
//               completion scoreboard plus reset and timeout sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;

   localparam int T  = 10;
   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        mem_req_valid, mem_req_ready, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic [31:0] raw_dmem;
   logic [2:0]  LdSel;
   logic [1:0]  shamt;
   logic        ld_valid, busy, timeout_err, misalign_err;

   dmem_access_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data), .raw_dmem(raw_dmem), .LdSel(LdSel),
      .shamt(shamt), .ld_valid(ld_valid), .busy(busy),
      .timeout_err(timeout_err), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          rdy_dly;
      int          resp_dly;
      logic        resp_en;
      logic [31:0] exp_addr;
      logic [3:0]  exp_mask;
      logic [31:0] exp_wdata;
   } vec_t;

   typedef struct {
      logic [31:0] raw;
      logic [2:0]  ldsel;
      logic [1:0]  shamt;
      logic        to;
      logic        mis;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   vec_t        tbl[11];
   int          n_vec = 0;
   int          n_mis = 0;
   int          n_done = 0;
   logic [31:0] model_raw = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Completion monitor: every ld_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && ld_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_ld_valid", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("raw_dmem", raw_dmem, mon_e.raw);
            chk("LdSel", 32'(LdSel), 32'(mon_e.ldsel));
            chk("shamt", 32'(shamt), 32'(mon_e.shamt));
            chk("timeout_err", 32'(timeout_err), 32'(mon_e.to));
            chk("misalign_err", 32'(misalign_err), 32'(mon_e.mis));
            chk("ld_valid_cycle", cyc, mon_e.cyc);
         end
         n_done++;
      end else if (timeout_err || misalign_err) begin
         chk("err_without_ld_valid", 32'd1, 32'd0);
      end
   end

   task automatic do_txn(input vec_t v);
      int unsigned a;
      int          start;
      int          k;
      logic        mis;
      exp_t        e;
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      chk("busy_idle", 32'(busy), 32'd0);
      req_valid = 1'b1;
      req_we    = v.we;
      req_size  = v.size;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      a   = cyc + 1;
      mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis = (((v.size == 3'b001) || (v.size == 3'b100)) && v.addr[0])
          || ((v.size == 3'b010) && (v.addr[1:0] != 2'b00));
`endif
      e.ldsel = v.size;
      e.shamt = v.addr[1:0];
      e.mis   = mis;
      e.to    = 1'b0;
      if (mis) begin
         e.raw = 32'h0;
         e.cyc = a;
      end else if (!v.resp_en) begin
         e.raw = 32'h0;
         e.to  = 1'b1;
         e.cyc = a + 1 + v.rdy_dly + T;
      end else begin
         e.raw = v.we ? model_raw : v.rdata;
         e.cyc = a + 2 + v.rdy_dly + v.resp_dly;
      end
      model_raw = e.raw;
      sb.push_back(e);
      start = n_done;
      @(negedge clk);
      req_valid = 1'b0;
      if (!mis) begin
         for (int i = 0; i <= v.rdy_dly; i++) begin
            chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
            chk("mem_addr", mem_addr, v.exp_addr);
            chk("mem_we", 32'(mem_we), 32'(v.we));
            chk("mem_wmask", 32'(mem_wmask), 32'(v.exp_mask));
            if (v.we && (v.size <= 3'b010)) chk("mem_wdata", mem_wdata, v.exp_wdata);
            chk("busy_req", 32'(busy), 32'd1);
            if (i == v.rdy_dly) mem_req_ready = 1'b1;
            @(negedge clk);
         end
         mem_req_ready = 1'b0;
         chk("mem_req_valid_wait", 32'(mem_req_valid), 32'd0);
         chk("busy_wait", 32'(busy), 32'd1);
         if (v.resp_en) begin
            repeat (v.resp_dly) @(negedge clk);
            mem_resp_valid = 1'b1;
            mem_resp_data  = v.rdata;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
         end
      end else begin
         chk("mem_req_valid_trap", 32'(mem_req_valid), 32'd0);
      end
      k = 0;
      while ((n_done == start) && (k < 3 * T + 10)) begin
         @(negedge clk);
         k++;
      end
      if (n_done == start) begin
         chk("ld_valid_never_seen", 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b0, 3'b010, 32'h0000_1000, 32'h0,         32'hDEADBEEF, 0, 0,     1'b1, 32'h0000_1000, 4'b0000, 32'h0};
      tbl[1]  = '{1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0,        0, 1,     1'b1, 32'h0000_2000, 4'b1000, 32'hA5A5A5A5};
      tbl[2]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, 32'h0,        5, 0,     1'b1, 32'h0000_2000, 4'b1100, 32'h12341234};
      tbl[3]  = '{1'b1, 3'b010, 32'h0000_4004, 32'hCAFEF00D,  32'h0,        1, 2,     1'b1, 32'h0000_4004, 4'b1111, 32'hCAFEF00D};
      tbl[4]  = '{1'b0, 3'b011, 32'h0000_5001, 32'h0,         32'h11223344, 2, 3,     1'b1, 32'h0000_5000, 4'b0000, 32'h0};
      tbl[5]  = '{1'b0, 3'b100, 32'h0000_6002, 32'h0,         32'h55667788, 0, T - 1, 1'b1, 32'h0000_6000, 4'b0000, 32'h0};
      tbl[6]  = '{1'b0, 3'b000, 32'h0000_7003, 32'h0,         32'h99999999, 0, 0,     1'b0, 32'h0000_7000, 4'b0000, 32'h0};
      tbl[7]  = '{1'b1, 3'b011, 32'h0000_8002, 32'h89ABCDEF,  32'h0,        0, 0,     1'b1, 32'h0000_8000, 4'b0000, 32'h0};
      tbl[8]  = '{1'b0, 3'b001, 32'h0000_3001, 32'h0,         32'hA1B2C3D4, 0, 1,     1'b1, 32'h0000_3000, 4'b0000, 32'h0};
      tbl[9]  = '{1'b1, 3'b000, 32'h0000_9001, 32'h0000_007F, 32'h0,        0, 0,     1'b0, 32'h0000_9000, 4'b0010, 32'h7F7F7F7F};
      tbl[10] = '{1'b0, 3'b010, 32'h0000_A008, 32'h0,         32'h0BADF00D, 0, 0,     1'b1, 32'h0000_A008, 4'b0000, 32'h0};

      rst_n          = 1'b0;
      req_valid      = 1'b0;
      req_we         = 1'b0;
      req_size       = 3'b000;
      req_addr       = 32'h0;
      req_wdata      = 32'h0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_raw_dmem", raw_dmem, 32'h0);
      chk("rst_LdSel", 32'(LdSel), 32'd0);
      chk("rst_shamt", 32'(shamt), 32'd0);
      chk("rst_ld_valid", 32'(ld_valid), 32'd0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      chk("rst_misalign_err", 32'(misalign_err), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) do_txn(tbl[i]);

      // Reset in the middle of WAIT_RESP; the late response must be dropped.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 3'b010;
      req_addr  = 32'h0000_B00C;
      @(negedge clk);
      req_valid     = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk("midrst_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_raw_dmem", raw_dmem, 32'h0);
      chk("midrst_LdSel", 32'(LdSel), 32'd0);
      chk("midrst_shamt", 32'(shamt), 32'd0);
      chk("midrst_mem_addr", mem_addr, 32'h0);
      chk("midrst_ld_valid", 32'(ld_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      for (int i = 0; i < 3; i++) begin
         chk("late_resp_ld_valid", 32'(ld_valid), 32'd0);
         chk("late_resp_raw_dmem", raw_dmem, 32'h0);
         chk("late_resp_busy", 32'(busy), 32'd0);
         @(negedge clk);
      end
      model_raw = 32'h0;
      do_txn('{1'b0, 3'b010, 32'h0000_C000, 32'h0, 32'h600D600D, 0, 0, 1'b1,
               32'h0000_C000, 4'b0000, 32'h0});

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
